// File: rtl/disp_share_arbiter.sv
// Round-robin owner of the shared 7-seg display and HC595 LED chain, with a minimum hold time.
// Optional DISP_ARB_PRIO_EN: req[0] becomes a preempting high-priority requester.
module disp_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   data,
  input  logic                 pin,
  output logic [NREQ-1:0]      grant,
  output logic [31:0]          display_data,
  output logic                 disp_en,
  output logic [15:0]          led_data,
  output logic                 led_load,
  output logic [1:0]           dbg_state
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

  localparam logic [CNT_W-1:0] EXPIRE = CNT_W'(HOLD_CYCLES - 2);

  logic [1:0]       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       sw_cnt;
  logic [IDX_W-1:0] last_owner;

  // Handshake: req is a level; the owner keeps it high to hold the display.
  // grant is the registered acknowledge, led_load pulses once per new owner.

  // Scan upward from last+1, wrapping, so the previous owner is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] w;
    logic             found;
    int               idx;
    w     = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && r[idx]) begin
        w     = IDX_W'(idx);
        found = 1'b1;
      end
    end
`ifdef DISP_ARB_PRIO_EN
    if (r[0] && last != '0) w = '0;
`endif
    return w;
  endfunction

  logic [IDX_W-1:0] winner;
  logic [NREQ-1:0]  win_onehot;
  logic [31:0]      winner_data;
  logic [31:0]      owner_data;
  logic             go_load;
  logic             go_idle;
  logic             restart;

  assign winner      = rr_pick(req, last_owner);
  assign win_onehot  = NREQ'(1) << winner;
  assign winner_data = data[32*winner +: 32];
  assign owner_data  = data[32*last_owner +: 32];
  assign dbg_state   = state;

  always_comb begin
    go_load = 1'b0;
    go_idle = 1'b0;
    restart = 1'b0;
    case (state)
      ST_IDLE: go_load = |req;
      ST_LOAD: ;
      ST_SHOW: begin
        if (!req[last_owner]) begin
          // Owner let go early: pin no longer applies, hand over or go dark.
          if (|req) go_load = 1'b1;
          else      go_idle = 1'b1;
        end
`ifdef DISP_ARB_PRIO_EN
        else if (!pin && last_owner != '0 && req[0]) begin
          go_load = 1'b1;
        end
`endif
        else if (hold_cnt == EXPIRE) begin
          if (pin)                       restart = 1'b1;
          else if (|(req & ~grant))      go_load = 1'b1;
          else                           restart = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      sw_cnt       <= '0;
      last_owner   <= IDX_W'(NREQ - 1);
      grant        <= '0;
      display_data <= '0;
      disp_en      <= 1'b0;
      led_data     <= '0;
      led_load     <= 1'b0;
    end else begin
      led_load <= 1'b0;
      if (go_load) begin
        state        <= ST_LOAD;
        grant        <= win_onehot;
        last_owner   <= winner;
        display_data <= winner_data;
        disp_en      <= 1'b1;
        hold_cnt     <= '0;
        sw_cnt       <= sw_cnt + 8'd1;
        led_load     <= 1'b1;
        led_data     <= {8'(win_onehot), sw_cnt + 8'd1};
      end else if (go_idle) begin
        state        <= ST_IDLE;
        grant        <= '0;
        display_data <= '0;
        disp_en      <= 1'b0;
        hold_cnt     <= '0;
      end else if (state == ST_LOAD) begin
        state        <= ST_SHOW;
        display_data <= owner_data;
      end else if (state == ST_SHOW) begin
        display_data <= owner_data;
        hold_cnt     <= restart ? '0 : hold_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Bench for disp_share_arbiter: directed test-plan scenarios plus random traffic,
// checked against an ownership-level reference model.
module tb_disp_share_arbiter;

  localparam int NREQ  = 4;
  localparam int HOLD  = 8;
  localparam int CNT_W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] data = '0;
  logic         pin = 1'b0;
  logic [3:0]   grant;
  logic [31:0]  display_data;
  logic         disp_en;
  logic [15:0]  led_data;
  logic         led_load;
  logic [1:0]   dbg_state;

  disp_share_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .data(data), .pin(pin),
    .grant(grant), .display_data(display_data), .disp_en(disp_en),
    .led_data(led_data), .led_load(led_load), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  // reference model: who owns the display and how many cycles remain
  int          m_owner;
  int          m_last;
  int          m_rem;
  int          m_sw;
  bit          m_in_load;
  logic [15:0] m_led;
  logic [31:0] m_disp;
  bit          m_load;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
`ifdef DISP_ARB_PRIO_EN
    if (r[0] && m_last != 0) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      int i = (m_last + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = NREQ - 1; m_rem = 0; m_sw = 0;
    m_in_load = 0; m_led = '0; m_disp = '0; m_load = 0;
    exp_q.delete();
  endtask

  task automatic take(input int w);
    m_owner   = w;
    m_last    = w;
    m_sw      = (m_sw + 1) % 256;
    m_load    = 1;
    m_led     = 16'(((1 << w) * 256) + m_sw);
    m_disp    = data[32*w +: 32];
    m_rem     = HOLD;
    m_in_load = 1;
  endtask

  task automatic model_step();
    logic [3:0] others;
    m_load = 0;
    if (m_owner < 0) begin
      if (req != 0) take(pick(req));
    end else if (m_in_load) begin
      m_in_load = 0;
      m_rem--;
      m_disp = data[32*m_owner +: 32];
    end else if (!req[m_owner]) begin
      if (req != 0) take(pick(req));
      else begin m_owner = -1; m_disp = '0; end
    end
`ifdef DISP_ARB_PRIO_EN
    else if (!pin && m_owner != 0 && req[0]) take(0);
`endif
    else if (m_rem == 1) begin
      others = req & ~4'(1 << m_owner);
      if (pin || others == 0) begin
        m_rem  = HOLD - 1;
        m_disp = data[32*m_owner +: 32];
      end else take(pick(req));
    end else begin
      m_rem--;
      m_disp = data[32*m_owner +: 32];
    end
  endtask

  task automatic check_outputs();
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
    check("grant", 32'(grant), 32'(eg));
    check("display_data", display_data, m_disp);
    check("disp_en", 32'(disp_en), 32'(m_owner >= 0));
    check("led_load", 32'(led_load), 32'(m_load));
    check("led_data", 32'(led_data), 32'(m_led));
    if (m_load) exp_q.push_back(m_led);
    if (led_load === 1'b1) begin
      if (exp_q.size() > 0) check("led_word", 32'(led_data), 32'(exp_q.pop_front()));
      else check("led_spurious", 32'(led_load), 32'd0);
    end
  endtask

  // driver: present inputs, step DUT and model on the edge, sample 1 ns later
  task automatic cycle(input logic [3:0] r, input logic p, input bit rnd_data);
    req = r;
    pin = p;
    if (rnd_data) data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    #3 reset_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_display", display_data, 32'd0);
    check("rst_en", 32'(disp_en), 32'd0);
    check("rst_led_data", 32'(led_data), 32'd0);
    check("rst_led_load", 32'(led_load), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int pulses;
  logic [3:0] r_cur;

  initial begin
    model_reset();
    #2;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_led_load", 32'(led_load), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: single requester
    data = {$urandom, $urandom, $urandom, 32'h12345678};
    cycle(4'b0001, 1'b0, 1'b0);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_display", display_data, 32'h12345678);
    check("t1_led_load", 32'(led_load), 32'd1);
    check("t1_led_data", 32'(led_data), 32'h0101);
    check("t1_en", 32'(disp_en), 32'd1);

    // 2: two requesters alternate with no idle gap
    for (int i = 0; i < 5 * HOLD; i++) cycle(4'b0101, 1'b0, 1'b1);

    // 3: owner 2 pinned across three expiries, then released
    for (int i = 0; i < 3 * HOLD && m_owner != 2; i++) cycle(4'b0101, 1'b0, 1'b1);
    check("t3_owner2", 32'(grant), 32'h4);
    pulses = 0;
    for (int i = 0; i < 3 * HOLD; i++) begin
      cycle(4'b1111, 1'b1, 1'b1);
      if (led_load) pulses++;
    end
    check("t3_pinned_pulses", 32'(pulses), 32'd0);
    check("t3_pinned_grant", 32'(grant), 32'h4);
    for (int i = 0; i < 2 * HOLD && !led_load; i++) cycle(4'b1111, 1'b0, 1'b1);
    check("t3_release_grant", 32'(grant), 32'h8);

    // 4: owner 1 drops early, another waiting / nobody waiting
    do_reset();
    cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0001, 1'b0, 1'b1);
    check("t4_handover", 32'(grant), 32'h1);
    do_reset();
    cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    check("t4_idle_en", 32'(disp_en), 32'd0);
    check("t4_idle_display", display_data, 32'd0);

    // 5: reset in the middle of SHOW
    for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b0, 1'b1);
    do_reset();
    cycle(4'b1111, 1'b0, 1'b1);
    check("t5_first_grant", 32'(grant), 32'h1);

    // 6: req[0] rising while owner 3 holds
    do_reset();
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b1001, 1'b0, 1'b1);
`ifdef DISP_ARB_PRIO_EN
    check("t6_preempt", 32'(grant), 32'h1);
`else
    check("t6_no_preempt", 32'(grant), 32'h8);
`endif
    for (int i = 0; i < HOLD; i++) cycle(4'b1001, 1'b0, 1'b1);

    // random traffic with slowly changing requests
    r_cur = 4'(($urandom_range(0, 15)));
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) r_cur = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(r_cur, ($urandom_range(0, 3) == 0), 1'b1);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_share_arbiter.md
Name: disp_share_arbiter

Overview:
- Shares the single 8-digit seven-segment display and the 16-bit HC595 LED chain among NREQ requesters, such as the PC, register-file probe, ALU result and debug word.
- Grants ownership round-robin with a guaranteed minimum hold time and registers the owner's 32-bit BCD word into the display driver.
- Issues a one-cycle LED-chain load pulse on every ownership change.
- Sits between the CPU debug taps and the display/LED drivers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 50000000, minimum ownership time in clk cycles (1 s at 50 MHz); must be ≥ 2.
- CNT_W, 26, hold-counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester display request, level
- data  in  32*NREQ  requester i word at data[32*i+:32], 8 BCD nibbles
- pin  in  1  freeze current owner at hold expiry
- grant  out  NREQ  one-hot current owner, registered
- display_data  out  32  word to display driver, registered
- disp_en  out  1  display enable
- led_data  out  16  LED-chain word
- led_load  out  1  one-cycle load strobe to LED driver s_en

Behaviour:
- Reset is asynchronous, active-low. Reset clk; reset_n, asynchronous, active-low.
  - Reset values: grant=0, display_data=0, disp_en=0, led_data=0, led_load=0, state=IDLE, hold counter=0, switch counter=0, last_owner=NREQ-1 so req[0] wins first.
- FSM states: IDLE, LOAD, SHOW.
- Arbitration function: choose the first set req bit scanning upward from last_owner+1 modulo NREQ, wrapping. last_owner itself is checked last.
- IDLE:
  - grant=0, disp_en=0, display_data held at 0.
  - If req≠0 at a clock edge, on that edge: grant←winner, last_owner←winner, display_data←winner's data, hold counter←0, state←LOAD.
  - Latency from req sampled to grant/display_data valid: 1 cycle.
- LOAD: exactly one cycle.
  - led_load=1.
  - led_data = {grant zero-extended to 8 bits, switch counter}; the switch counter is 8-bit and increments on entering LOAD, wrapping 255→0.
  - Next state SHOW.
- SHOW:
  - display_data ← owner's live data every cycle (1-cycle latency); disp_en=1; hold counter increments.
  - Total ownership before expiry is HOLD_CYCLES cycles, counting the LOAD cycle.
- Hold expiry (counter = HOLD_CYCLES-2 in SHOW), evaluated in priority order:
  1. pin=1 and owner req=1: stay, counter←0, no led_load.
  2. Another requester active: direct SHOW→LOAD to the arbitration winner, with no IDLE gap.
  3. Only the owner requesting: stay, counter←0, no led_load.
  4. req=0: IDLE next cycle; grant, display_data and disp_en go to 0.
- Owner drops req before expiry: pin is ignored. Re-arbitrate on the next edge, excluding the current owner, going to LOAD or IDLE.
- Non-owner req changes during hold have no effect until expiry.
- grant is always one-hot or zero; led_data holds between LOAD cycles.
- Reset mid-operation: all outputs return to reset values immediately, asynchronously. The LED driver sees no led_load.

Optional Feature:
- Macro: DISP_ARB_PRIO_EN.
- Defined: req[0] is a high-priority requester. While pin=0 and the owner is not 0, req[0]=1 preempts on the next edge regardless of the hold counter, going to LOAD with grant=0001. At expiry, req[0] also wins over round-robin order.
- Undefined: pure round-robin; req[0] has no special treatment.

Test Plan (NREQ=4, HOLD_CYCLES=8):
1. Reset, then req=0001 with data0=32'h12345678 → after 1 cycle: grant=0001, display_data=12345678, led_load pulse=1 for one cycle, led_data=16'h0101, disp_en=1.
2. req=0101 held steady → grant alternates 0001, 0100 every 8 cycles with no IDLE gap. The switch count in led_data[7:0] increments 1, 2, 3….
3. Owner 2 with pin=1 and req=1111 → ownership is retained across 3 expiries with no led_load. Drop pin → grant=1000 at the next expiry.
4. Owner 1 drops req at cycle 3 of its hold, with req=0001 → grant=0001 on the following edge. With req=0000 instead → IDLE: disp_en=0, display_data=0.
5. Assert reset_n=0 mid-SHOW → all outputs 0 immediately. After release with req=1111 → grant=0001 first.
6. With DISP_ARB_PRIO_EN defined: owner 3, cycle 2, req[0] rises → grant=0001 next edge, led_load=1. Undefined → grant=0001 only at expiry.
